mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
Iterative multiply/divide unit in the EX stage, alongside the ALU. It takes the same register-file operands (inA = rs, inB = rt) and produces the HI/LO register pair for MULT/MULTU/DIV/DIVU. It computes one bit per cycle. While busy it asserts a stall to the pipeline. It also services MTHI/MTLO writes and continuously presents HI/LO for MFHI/MFLO.

Parameters:
N, 32, operand width; HI and LO are each N bits; iteration count = N.
CW, 6, iteration counter width; must satisfy 2^CW > N.

Ports:
clock  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high; sampled on posedge clock.
start  input  1  request a new operation; accepted only when busy=0.
op  input  2  operation select, latched at accept: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
inA  input  N  rs operand (multiplicand / dividend), latched at accept.
inB  input  N  rt operand (multiplier / divisor), latched at accept.
wen_hi  input  1  MTHI write enable.
wen_lo  input  1  MTLO write enable.
wd  input  N  MTHI/MTLO write data.
busy  output  1  high from the cycle after accept until the result is written; drives pipeline stall.
done  output  1  one-cycle pulse, coincident with HI/LO taking the new result.
hi  output  N  HI register (product upper half / remainder).
lo  output  N  LO register (product lower half / quotient).

Behaviour:
- Reset (posedge clock with reset=1): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0. Reset overrides everything, including an in-flight operation; that operation's result is discarded.
- States: IDLE, RUN, FINISH. busy=1 in RUN and FINISH only. done is registered, so it is high during the first IDLE cycle after FINISH.
- IDLE to RUN (accept edge k): start=1 and not busy. On this edge:
  - latch op;
  - for signed ops, latch |inA| and |inB| plus the result signs;
  - clear the accumulator and counter.
- RUN: one iteration per edge, k+1..k+N.
  - Multiply: shift-add. If the multiplier LSB is 1, add the multiplicand into the upper half; then shift the 2N-bit accumulator right by 1.
  - Divide: restoring. Shift the remainder:quotient pair left by 1, trial-subtract the divisor, keep the result if non-negative, and set the quotient LSB accordingly.
  - After the N-th iteration: RUN to FINISH.
- FINISH to IDLE (edge k+N+1):
  - apply sign fixup;
  - write hi/lo;
  - done=1 for exactly one cycle;
  - busy=0 from this edge on.
  - Total latency: result visible N+1 edges after the accept edge (33 for N=32).
- Signed rules:
  - MULT: product negated if sign(inA) xor sign(inB).
  - DIV: quotient sign = sign(inA) xor sign(inB); remainder sign = sign(inA).
  - Results are truncated to N bits. DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
- Divide by zero (inB=0, DIV or DIVU): the full N-cycle sequence still runs. Result: lo = all ones, hi = inA (original, unsigned view). No exception is raised.
- start while busy: ignored. No queueing; the in-flight operation is unaffected.
- MTHI/MTLO:
  - when busy=0: hi<=wd if wen_hi, lo<=wd if wen_lo, on the same edge;
  - when busy=1: ignored;
  - on the same edge as an accepted start: the write takes effect and is later overwritten by the result at FINISH.
- MULT/DIV never writes the register file directly; MFHI/MFLO read the hi/lo outputs combinationally.

Decomposition:
- Shared constants in constants.h:
  - op codes MD_MULT=2'b00, MD_MULTU=2'b01, MD_DIV=2'b10, MD_DIVU=2'b11;
  - state encodings MD_IDLE, MD_RUN, MD_FINISH.
- Single module; no sub-module needed. Absolute-value and negate helpers are local functions.

Test Plan:
- Reset held for 2 cycles, then released -> hi=0, lo=0, busy=0, done=0; then a start during reset is ignored.
- MULTU inA=0xFFFFFFFF, inB=2 at edge k -> busy=1 during edges k+1..k+32; at edge k+33 hi=0x00000001, lo=0xFFFFFFFE, done pulses once.
- MULT inA=0xFFFFFFFF (-1), inB=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE; DIV inA=-7, inB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
- DIVU inA=0x1234, inB=0 -> after 33 edges lo=0xFFFFFFFF, hi=0x1234; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Second start with different operands mid-RUN -> ignored; the first result is delivered at edge k+33. wen_hi with wd=0xAAAA mid-RUN -> ignored. wen_lo with wd=0x5555 while idle -> lo=0x5555 next edge.
- reset=1 at edge k+10 of a MULT -> edge k+10 gives state IDLE, busy=0, hi=lo=0; no done pulse follows.

Source files
------------

// File: rtl/mult_div_unit_pkg.sv
// Shared encodings for the iterative multiply/divide unit:
// operation codes as seen on the op port, and the FSM state encoding.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE   = 2'b00,
    MD_RUN    = 2'b01,
    MD_FINISH = 2'b10
  } md_state_e;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit: one bit per cycle, shift-add multiply and
// restoring divide on magnitudes, with sign fixup applied when the result is written.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         wen_hi,
  input  logic         wen_lo,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  function automatic logic [N-1:0] abs_val(input logic [N-1:0] x);
    return x[N-1] ? -x : x;
  endfunction

  function automatic logic [N-1:0] neg_if(input logic neg, input logic [N-1:0] x);
    return neg ? -x : x;
  endfunction

  md_state_e      state, state_next;
  md_op_e         op_q;
  logic           neg_lo_q, neg_hi_q;
  logic [N-1:0]   opnd_q;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  count;

  // Operand preparation at accept time. A signed divide by zero keeps the raw
  // dividend so the unsigned iteration naturally leaves hi = inA, lo = all ones.
  logic         is_mult_in, div_zero, use_abs;
  logic [N-1:0] a_val, b_val;

  assign is_mult_in = ~op[1];
  assign div_zero   = op[1] & (inB == '0);
  assign use_abs    = ~op[0] & ~div_zero;
  assign a_val      = use_abs ? abs_val(inA) : inA;
  assign b_val      = use_abs ? abs_val(inB) : inB;

  // Iteration datapath: acc holds {product_hi, multiplier} or {remainder, quotient}.
  logic           is_mult_q, last_iter, trial_ok;
  logic [N:0]     mul_sum, rem_sh;
  logic [2*N-1:0] mul_next, div_next, prod_fix;

  assign is_mult_q = (op_q == MD_MULT) || (op_q == MD_MULTU);
  assign last_iter = (count == CW'(N - 1));
  assign mul_sum   = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd_q} : '0);
  assign mul_next  = {mul_sum, acc[N-1:1]};
  assign rem_sh    = {acc[2*N-1:N], acc[N-1]};
  assign trial_ok  = (rem_sh >= {1'b0, opnd_q});
  assign div_next  = trial_ok ? {rem_sh[N-1:0] - opnd_q, acc[N-2:0], 1'b1}
                              : {rem_sh[N-1:0], acc[N-2:0], 1'b0};
  assign prod_fix  = neg_lo_q ? -acc : acc;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) state <= MD_IDLE;
    else       state <= state_next;
  end

  // NOTE: default assignment first keeps this combinational and latch-free.
  always_comb begin
    state_next = state;
    case (state)
      MD_IDLE:   if (start) state_next = MD_RUN;
      MD_RUN:    if (last_iter) state_next = MD_FINISH;
      MD_FINISH: state_next = MD_IDLE;
      default:   state_next = MD_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    if (state != MD_IDLE) busy = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      count    <= '0;
      acc      <= '0;
      opnd_q   <= '0;
      op_q     <= MD_MULT;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        MD_IDLE: begin
          if (wen_hi) hi <= wd;
          if (wen_lo) lo <= wd;
          if (start) begin
            op_q     <= md_op_e'(op);
            neg_lo_q <= use_abs & (inA[N-1] ^ inB[N-1]);
            neg_hi_q <= use_abs & inA[N-1];
            opnd_q   <= is_mult_in ? a_val : b_val;
            acc      <= {{N{1'b0}}, (is_mult_in ? b_val : a_val)};
            count    <= '0;
          end
        end
        MD_RUN: begin
          acc   <= is_mult_q ? mul_next : div_next;
          count <= count + CW'(1);
        end
        MD_FINISH: begin
          if (is_mult_q) begin
            hi <= prod_fix[2*N-1:N];
            lo <= prod_fix[N-1:0];
          end else begin
            hi <= neg_if(neg_hi_q, acc[2*N-1:N]);
            lo <= neg_if(neg_lo_q, acc[N-1:0]);
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
